// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD byte writer.
package lcd_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ROM_IDX_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_PWR_WAIT = 3'd0;
  localparam state_t ST_LOAD     = 3'd1;
  localparam state_t ST_E_HIGH   = 3'd2;
  localparam state_t ST_E_LOW    = 3'd3;
  localparam state_t ST_EXEC     = 3'd4;
  localparam state_t ST_IDLE     = 3'd5;

  typedef enum logic [2:0] {
    W250NS   = 3'd0,
    W42US    = 3'd1,
    W100US   = 3'd2,
    W1640US  = 3'd3,
    W4100US  = 3'd4,
    W15000US = 3'd5
  } wsel_e;

  typedef struct packed {
    logic [DATA_W-1:0] cmd;
    wsel_e             wsel;
  } init_entry_t;

  localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;
  localparam logic [DATA_W-1:0] CMD_HOME  = 8'h02;

  // Power-on command sequence with the execution wait each command needs.
  function automatic init_entry_t init_rom(input logic [ROM_IDX_W-1:0] idx);
    init_entry_t e;
    case (idx)
      3'd0:    e = '{cmd: 8'h30, wsel: W4100US};
      3'd1:    e = '{cmd: 8'h30, wsel: W100US};
      3'd2:    e = '{cmd: 8'h30, wsel: W42US};
      3'd3:    e = '{cmd: 8'h38, wsel: W42US};
      3'd4:    e = '{cmd: 8'h08, wsel: W42US};
      3'd5:    e = '{cmd: CMD_CLEAR, wsel: W1640US};
      3'd6:    e = '{cmd: 8'h06, wsel: W42US};
      default: e = '{cmd: 8'h0C, wsel: W42US};
    endcase
    return e;
  endfunction

  // Clear and return-home (0x02/0x03) are the slow commands; everything else is 42us.
  function automatic wsel_e host_wait(input logic rs, input logic [DATA_W-1:0] data);
    if (!rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03))
      return W1640US;
    return W42US;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// HD44780 8-bit bus writer: power-on init sequence, then one host byte at a time,
// paced by the sticky flags of an external flag timer.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_rs,
  input  logic [DATA_W-1:0] in_data,
  output logic              init_done,
  output logic              flag_rst,
  input  logic              flag_250ns,
  input  logic              flag_42us,
  input  logic              flag_100us,
  input  logic              flag_1640us,
  input  logic              flag_4100us,
  input  logic              flag_15000us,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic [DATA_W-1:0] lcd_data
);

  localparam int unsigned IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

  state_t            state_q, state_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  wsel_e             wsel_q, wsel_nxt;
  logic              flag_rst_dly;
  logic              flag_rst_nxt;
  logic              in_ready_nxt;
  logic              init_done_nxt;
  logic              lcd_e_nxt;
  logic              lcd_rs_nxt;
  logic [DATA_W-1:0] lcd_data_nxt;
  logic              flag_ok;
  logic              sel_flag;
  init_entry_t       rom_first;
  init_entry_t       rom_next;

  assign lcd_rw = 1'b0;

  // Flags are stale in the restart cycle and the one after it.
  assign flag_ok = !flag_rst && !flag_rst_dly;

  // Wait-select mux picks the flag that ends the current execution wait.
  always_comb begin
    case (wsel_q)
      W250NS:   sel_flag = flag_250ns;
      W42US:    sel_flag = flag_42us;
      W100US:   sel_flag = flag_100us;
      W1640US:  sel_flag = flag_1640us;
      W4100US:  sel_flag = flag_4100us;
      default:  sel_flag = flag_15000us;
    endcase
  end

  // Next state and next registered outputs; outputs follow the state being entered.
  always_comb begin
    state_nxt     = state_q;
    idx_nxt       = idx_q;
    wsel_nxt      = wsel_q;
    flag_rst_nxt  = 1'b0;
    init_done_nxt = init_done;
    lcd_rs_nxt    = lcd_rs;
    lcd_data_nxt  = lcd_data;
    rom_first     = init_rom(ROM_IDX_W'(0));
    rom_next      = init_rom(ROM_IDX_W'(idx_q + IDX_W'(1)));

    case (state_q)
      ST_PWR_WAIT: begin
        if (flag_ok && flag_15000us) begin
          state_nxt    = ST_LOAD;
          idx_nxt      = '0;
          lcd_rs_nxt   = 1'b0;
          lcd_data_nxt = rom_first.cmd;
          wsel_nxt     = rom_first.wsel;
          flag_rst_nxt = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_E_HIGH;
      end
      ST_E_HIGH: begin
        if (flag_ok && flag_250ns) begin
          state_nxt    = ST_E_LOW;
          flag_rst_nxt = 1'b1;
        end
      end
      ST_E_LOW: begin
        if (flag_ok && flag_250ns) begin
          state_nxt    = ST_EXEC;
          flag_rst_nxt = 1'b1;
        end
      end
      ST_EXEC: begin
        if (flag_ok && sel_flag) begin
          if (init_done) begin
            state_nxt = ST_IDLE;
          end else if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            state_nxt     = ST_IDLE;
            init_done_nxt = 1'b1;
          end else begin
            state_nxt    = ST_LOAD;
            idx_nxt      = idx_q + IDX_W'(1);
            lcd_rs_nxt   = 1'b0;
            lcd_data_nxt = rom_next.cmd;
            wsel_nxt     = rom_next.wsel;
            flag_rst_nxt = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt    = ST_LOAD;
          lcd_rs_nxt   = in_rs;
          lcd_data_nxt = in_data;
          wsel_nxt     = host_wait(in_rs, in_data);
          flag_rst_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_PWR_WAIT;
        flag_rst_nxt = 1'b1;
      end
    endcase

    lcd_e_nxt    = (state_nxt == ST_E_HIGH);
    in_ready_nxt = (state_nxt == ST_IDLE);
  end

  // State and output registers; reset forces the bus idle and holds the timer in restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PWR_WAIT;
      idx_q        <= '0;
      wsel_q       <= W15000US;
      flag_rst     <= 1'b1;
      flag_rst_dly <= 1'b1;
      in_ready     <= 1'b0;
      init_done    <= 1'b0;
      lcd_e        <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_data     <= '0;
    end else begin
      state_q      <= state_nxt;
      idx_q        <= idx_nxt;
      wsel_q       <= wsel_nxt;
      flag_rst     <= flag_rst_nxt;
      flag_rst_dly <= flag_rst;
      in_ready     <= in_ready_nxt;
      init_done    <= init_done_nxt;
      lcd_e        <= lcd_e_nxt;
      lcd_rs       <= lcd_rs_nxt;
      lcd_data     <= lcd_data_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer with a reduced-threshold flag timer model.
module tb_lcd_byte_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       init_done;
  logic       flag_rst;
  logic       flag_250ns = 1'b0;
  logic       flag_42us = 1'b0;
  logic       flag_100us = 1'b0;
  logic       flag_1640us = 1'b0;
  logic       flag_4100us = 1'b0;
  logic       flag_15000us = 1'b0;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  int tests = 0;
  int fails = 0;

  lcd_byte_writer #(.INIT_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_data(in_data),
    .init_done(init_done), .flag_rst(flag_rst),
    .flag_250ns(flag_250ns), .flag_42us(flag_42us), .flag_100us(flag_100us),
    .flag_1640us(flag_1640us), .flag_4100us(flag_4100us), .flag_15000us(flag_15000us),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  // Timer model: registered sticky flags, so they stay stale through the restart cycle and the next.
  logic [7:0] tcnt = 8'd0;
  always @(posedge clk) begin
    if (flag_rst) tcnt <= 8'd0;
    else if (tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
    flag_250ns   <= (tcnt >= 8'd2);
    flag_42us    <= (tcnt >= 8'd5);
    flag_100us   <= (tcnt >= 8'd7);
    flag_1640us  <= (tcnt >= 8'd20);
    flag_4100us  <= (tcnt >= 8'd30);
    flag_15000us <= (tcnt >= 8'd40);
  end

  // Bus monitor: logs {rs,data} at each E rise, E high widths, and flag_rst pulse count.
  logic       e_prev = 1'b0;
  logic       fr_prev = 1'b0;
  int         e_width = 0;
  int         fr_pulses = 0;
  logic [8:0] e_log[$];
  int         w_log[$];
  always @(negedge clk) begin
    if (lcd_e && !e_prev) e_log.push_back({lcd_rs, lcd_data});
    if (lcd_e) e_width <= e_width + 1;
    else if (e_prev) begin
      w_log.push_back(e_width);
      e_width <= 0;
    end
    if (flag_rst && !fr_prev) fr_pulses <= fr_pulses + 1;
    e_prev  <= lcd_e;
    fr_prev <= flag_rst;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int bound, output int n, output logic pf42,
                            output logic pf1640, output logic saw42);
    n = 0; saw42 = 1'b0; pf42 = flag_42us; pf1640 = flag_1640us;
    while (!in_ready && n < bound) begin
      pf42 = flag_42us; pf1640 = flag_1640us;
      @(negedge clk); n++;
      if (!in_ready && flag_42us) saw42 = 1'b1;
    end
  endtask

  task automatic wait_first_e(output int n, output logic saw15k);
    n = 0; saw15k = 1'b0;
    while (!lcd_e && n < 200) begin
      @(negedge clk); n++;
      if (flag_15000us) saw15k = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_init [8];
    int   n, sz0, sz1, fr0;
    logic pf42, pf1640, saw42, saw15k;
    exp_init = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

    rst = 1'b1; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_flag_rst",  32'(flag_rst), 32'd1);
    check("rst_in_ready",  32'(in_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_lcd_e",     32'(lcd_e), 32'd0);
    check("rst_lcd_rs",    32'(lcd_rs), 32'd0);
    check("rst_lcd_rw",    32'(lcd_rw), 32'd0);
    check("rst_lcd_data",  32'(lcd_data), 32'h00);

    // Request held through the whole init sequence.
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h41;
    rst = 1'b0;
    @(negedge clk);
    check("flag_rst_drops", 32'(flag_rst), 32'd0);
    wait_first_e(n, saw15k);
    check("first_e_rise_seen", 32'(lcd_e), 32'd1);
    check("first_e_after_15000", 32'(saw15k), 32'd1);
    check("first_e_not_early", 32'(n >= 41), 32'd1);

    n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    check("init_done_set", 32'(init_done), 32'd1);
    check("init_ready_set", 32'(in_ready), 32'd1);
    check("init_pulse_count", 32'(e_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("init_byte_%0d", i), 32'(e_log[i]), 32'({1'b0, exp_init[i]}));
      check($sformatf("init_e_width_%0d", i), 32'(w_log[i]), 32'd4);
    end

    // Held 0x41 data byte transfers on the first IDLE edge.
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("data_ready_drop", 32'(in_ready), 32'd0);
    wait_ready(100, n, pf42, pf1640, saw42);
    check("data_ready_latency", 32'(n), 32'd18);
    check("data_ready_after_42", 32'(pf42), 32'd1);
    check("data_pulse_count", 32'(e_log.size()), 32'd9);
    check("data_byte", 32'(e_log[8]), 32'h141);
    check("data_hold_rs", 32'(lcd_rs), 32'd1);
    check("data_hold_bus", 32'(lcd_data), 32'h41);
    check("data_e_width", 32'(w_log[8]), 32'd4);

    // Clear command needs the long wait.
    @(negedge clk);
    in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h01;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_ready(100, n, pf42, pf1640, saw42);
    check("clear_ready_latency", 32'(n), 32'd33);
    check("clear_busy_during_42", 32'(saw42), 32'd1);
    check("clear_ready_after_1640", 32'(pf1640), 32'd1);
    check("clear_byte", 32'(e_log[9]), 32'h001);

    // Valid held across two back-to-back bytes.
    @(negedge clk);
    fr0 = fr_pulses; sz0 = e_log.size();
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h48;
    @(posedge clk); @(negedge clk);
    in_data = 8'h49;
    check("hold_busy", 32'(in_ready), 32'd0);
    wait_ready(100, n, pf42, pf1640, saw42);
    check("hold_first_latency", 32'(n), 32'd18);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    wait_ready(100, n, pf42, pf1640, saw42);
    check("hold_second_latency", 32'(n), 32'd18);
    repeat (3) @(negedge clk);
    check("hold_two_pulses", 32'(e_log.size() - sz0), 32'd2);
    check("hold_byte_0", 32'(e_log[sz0]), 32'h148);
    check("hold_byte_1", 32'(e_log[sz0 + 1]), 32'h149);
    check("hold_flag_rst_pulses", 32'(fr_pulses - fr0), 32'd6);
    check("rw_low", 32'(lcd_rw), 32'd0);

    // Asynchronous reset in the middle of an E high phase.
    in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h55;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 20) begin @(negedge clk); n++; end
    check("mid_e_high_reached", 32'(lcd_e), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_e", 32'(lcd_e), 32'd0);
    check("async_rst_flag_rst", 32'(flag_rst), 32'd1);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    check("async_rst_init_done", 32'(init_done), 32'd0);
    check("async_rst_data", 32'(lcd_data), 32'h00);
    repeat (3) @(negedge clk);
    sz1 = e_log.size();
    rst = 1'b0;
    wait_first_e(n, saw15k);
    check("reinit_e_seen", 32'(lcd_e), 32'd1);
    check("reinit_after_15000", 32'(saw15k), 32'd1);
    check("reinit_not_early", 32'(n >= 41), 32'd1);
    @(negedge clk);
    check("reinit_first_byte", 32'(e_log[sz1]), 32'h030);
    check("reinit_not_done", 32'(init_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

HD44780-style 8-bit LCD bus driver that consumes the flag-timer interface: it issues `flag_rst` pulses and advances on the timer's sticky elapsed-time flags. After reset it runs the power-on initialisation sequence, then accepts one byte at a time (command or data) over a valid/ready handshake and drives RS/RW/E/DB with the required enable pulse and execution waits. It sits between the display-content logic and the LCD pins, next to the flag timer instance in the LCD top level.

## Interface
Parameters:
- `INIT_LEN`, 8: number of init-sequence commands.

Ports:
- `clk`  in  1  system clock (50 MHz, same clock as the flag timer).
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  byte request valid.
- `in_ready`  out  1  block can accept a byte.
- `in_rs`  in  1  0 = command, 1 = data.
- `in_data`  in  8  byte to write.
- `init_done`  out  1  power-on sequence complete (sticky until reset).
- `flag_rst`  out  1  timer restart request to the flag timer.
- `flag_250ns`, `flag_42us`, `flag_100us`, `flag_1640us`, `flag_4100us`, `flag_15000us`  in  1 each  sticky elapsed flags from the timer.
- `lcd_e`, `lcd_rs`, `lcd_rw`  out  1 each  LCD control lines.
- `lcd_data`  out  8  LCD data bus.

## Operation
- Reset values: `flag_rst`=1, `in_ready`=0, `init_done`=0, `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00. `lcd_rw` is constant 0 (write-only; no busy-flag read).
- States: PWR_WAIT, LOAD, E_HIGH, E_LOW, EXEC, IDLE.
- PWR_WAIT: entered out of reset. `flag_rst` drops the first cycle after reset release. Wait for `flag_15000us`, then LOAD with init index 0.
- Init ROM, all RS=0. Each entry is a command and its exec-wait flag:
  - 0x30 / 4100us
  - 0x30 / 100us
  - 0x30 / 42us
  - 0x38 / 42us
  - 0x08 / 42us
  - 0x01 / 1640us
  - 0x06 / 42us
  - 0x0C / 42us
- LOAD (1 cycle): latch RS, data and wait-select onto `lcd_rs`/`lcd_data`; pulse `flag_rst`. Go to E_HIGH.
- E_HIGH: `lcd_e`=1. Wait for `flag_250ns`, then pulse `flag_rst` and go to E_LOW.
- E_LOW: `lcd_e`=0. Wait for `flag_250ns`, then pulse `flag_rst` and go to EXEC.
- EXEC: wait for the selected flag.
  - Host bytes: `flag_1640us` if RS=0 and data is 0x01, 0x02 or 0x03; otherwise `flag_42us`.
  - During init: next ROM entry via LOAD; after the last entry, set `init_done` and go to IDLE.
  - Host byte: go to IDLE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `in_rs`/`in_data`, drop `in_ready` and go to LOAD.
- `lcd_rs` and `lcd_data` stay stable from LOAD until the next LOAD. They hold their last values in IDLE.

## Timing
- `flag_rst` is a single-cycle pulse and is registered. Flags are sticky, so they are stale in the pulse cycle. The block ignores every flag in the cycle `flag_rst`=1 and in the cycle after it. The state advances on the first later cycle in which the selected flag is 1.
- Handshake: the transfer happens on the clock edge where `in_valid`=`in_ready`=1. `in_ready` is 0 from the next cycle until the host-byte EXEC completes. IDLE is re-entered for at least 1 cycle between bytes.
- `in_valid` during init or while busy is ignored. No buffering, no loss of a held request.
- `lcd_e` high time ≥ 250 ns. The low phase before EXEC is ≥ 250 ns. Setup time is ≥ 1 cycle (LOAD) before `lcd_e` rises.
- Reset mid-operation, asynchronous: outputs go to their reset values immediately (`lcd_e` drops without waiting for a clock). The full init sequence restarts.

## Structure
- Shared package `lcd_pkg`:
  - state enum.
  - wait-select enum (W250NS, W42US, W100US, W1640US, W4100US, W15000US).
  - init ROM constants (command, wait pairs).
  - command codes CMD_CLEAR=0x01, CMD_HOME=0x02.
  - helper function mapping (rs, data) to a wait-select.
- No sub-module. A wait-select mux selects the active flag. The flag timer is instantiated beside this block in the LCD top; `flag_rst` connects to its restart input and the six flags to its outputs.

## Test plan
- Bench timer model with reduced thresholds (e.g. 250ns=2, 42us=5, 100us=7, 1640us=20, 4100us=30, 15000us=40 cycles).
- Reset release → first `lcd_e` rise only after `flag_15000us`. Exactly 8 E pulses carry 0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C with `lcd_rs`=0. `init_done`=1 and `in_ready`=1 after the final 42us wait.
- After init, send `in_rs`=1, `in_data`=0x41 → one E pulse with `lcd_rs`=1, `lcd_data`=0x41. `in_ready` returns only after `flag_42us`.
- Send command 0x01 → `in_ready` stays 0 while `flag_42us`=1 and rises only after `flag_1640us`.
- Hold `in_valid`=1 during init and across two bytes (0x48, 0x49) → nothing is captured before `init_done`. Then exactly two transfers, each with its own `flag_rst` pulses and E pulse.
- Timer model leaves all flags high (stale) at each `flag_rst` → no state advance in the pulse cycle or the one after it.
- Assert `rst` mid-E_HIGH → `lcd_e`=0 and `flag_rst`=1 before the next clock edge. After release, init restarts from PWR_WAIT.
